reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Staged reset-release sequencer for the video-input clock domain. It sits directly downstream of the reset debouncer: the debouncer's asserted-high async reset, inverted, drives `rst_n`, and the PLL lock flag is consumed here. Once lock has been stable for a programmable time, it releases NUM_STAGES downstream reset domains one by one (capture front-end, sync detector, sampler, character encoder). It also supports a soft-reset request and, optionally, lock-loss recovery.

## Interface
- NUM_STAGES, 4: number of staged reset outputs, 1..8
- LOCK_STABLE, 64: cycles synchronized lock must stay high before release, ≥2
- STAGE_GAP, 16: cycles between consecutive stage releases, ≥1
- CNT_W, 8: internal counter width; must satisfy 2^CNT_W > max(LOCK_STABLE, STAGE_GAP)

- clk  in  1  video-input domain clock
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- soft_rst_req  in  1  single-cycle request to re-run the sequence
- stage_rst_n  out  NUM_STAGES  per-domain active-low resets; bit 0 released first
- seq_done  out  1  high while all stages are released (RUN state)
- lock_lost_cnt  out  8  saturating count of lock-loss aborts

## Operation
- **Lock synchronizer:** `pll_locked` passes through 2 flops to give `lock_s`. All decisions use `lock_s`.
- **State machine:** WAIT_LOCK, STABLE, RELEASE, RUN. Counter `cnt` and stage index `idx` are internal.
- **WAIT_LOCK:** all `stage_rst_n`=0, `cnt`=0. If `lock_s`=1, go to STABLE with `cnt`=0.
- **STABLE:**
  - `lock_s`=0 → WAIT_LOCK.
  - Otherwise `cnt`++.
  - At `cnt`==LOCK_STABLE-1 → RELEASE with `stage_rst_n[0]`=1 on the same edge, `idx`=0, `cnt`=0.
  - If NUM_STAGES=1 the target is RUN instead of RELEASE.
- **RELEASE:**
  - `cnt`++. At `cnt`==STAGE_GAP-1, set `stage_rst_n[idx+1]`=1, `idx`++, `cnt`=0.
  - When the last stage is released, go to RUN on the same edge.
  - Released stages stay released.
- **RUN:** `seq_done`=1. Hold until a soft reset or lock loss.
- **soft_rst_req** (states STABLE, RELEASE, RUN):
  - Next edge: all `stage_rst_n`=0, `seq_done`=0, state WAIT_LOCK.
  - Ignored in WAIT_LOCK.
  - Takes priority over any same-cycle transition.
- **Lock loss in RELEASE/RUN:** see Configuration.
- **lock_lost_cnt:** +1 per lock-loss abort, saturates at 255, cleared only by `rst_n`.
- **Reset assertion:** all state clears immediately (asynchronous); mid-sequence reset aborts the sequence.

## Timing
- Reset values:
  - `stage_rst_n`=0, `seq_done`=0, `lock_lost_cnt`=0
  - state WAIT_LOCK, sync flops 0
- All outputs are registered; no combinational path from input to output.
- Latency, with `pll_locked` rising before edge E and staying high (N = stage index):
  - `lock_s`=1 after E+1
  - STABLE entered at E+2
  - `stage_rst_n[0]` rises at E+2+LOCK_STABLE
  - `stage_rst_n[N]` rises at E+2+LOCK_STABLE+N·STAGE_GAP
  - `seq_done` rises on the same edge as the last stage
- A soft-reset/lock-loss abort asserts every `stage_rst_n` on one edge (no staged assertion).
- After an abort with lock still high, STABLE is re-entered 1 cycle later and the full LOCK_STABLE wait restarts.
- A lock glitch shorter than 1 cycle may be missed by the synchronizer; this is acceptable.

## Configuration
- Macro `RESET_SEQUENCER_LOCK_MON_EN`.
- **Defined:** `lock_s`=0 in RELEASE or RUN → next edge all stages asserted, `seq_done`=0, WAIT_LOCK, `lock_lost_cnt`++ (saturating).
- **Undefined:**
  - Lock is monitored only in WAIT_LOCK/STABLE.
  - Loss during RELEASE continues the sequence; RUN is held.
  - `lock_lost_cnt` is tied to 0.

## Test plan
1. Defaults, `rst_n` released, `pll_locked` rises before edge 10 → `stage_rst_n` = 0001 at edge 76, 0011 at 92, 0111 at 108, 1111 plus `seq_done`=1 at 124.
2. Lock high 30 cycles, low 5, high again → no stage released until 66 cycles after the second rise; `lock_lost_cnt` stays 0.
3. In RUN, pulse `soft_rst_req` 1 cycle → next edge `stage_rst_n`=0000, `seq_done`=0; full sequence repeats; `stage_rst_n[0]` rises 66 cycles after the pulse edge.
4. Macro defined; drop lock during RELEASE with 2 stages released → next edge 0000, `lock_lost_cnt`=1. Repeat 300 aborts → count = 255.
5. Macro undefined; drop lock in RUN → outputs hold 1111, `seq_done`=1, `lock_lost_cnt`=0.
6. Assert `rst_n`=0 mid-RELEASE → outputs 0 immediately without a clock edge. NUM_STAGES=1, LOCK_STABLE=2 → `seq_done` and `stage_rst_n[0]` rise together at E+4.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release after stable PLL lock, with soft reset and optional
// lock-loss abort (RESET_SEQUENCER_LOCK_MON_EN).
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int LOCK_STABLE = 64,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic [7:0]            lock_lost_cnt
);
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;
  state_t r_state, w_state;
  logic r_sync1, r_lock_s;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [NUM_STAGES-1:0] r_stage, w_stage, w_shift;
  logic r_done, w_done;
  logic [7:0] r_lost, w_lost;
  logic w_abort;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_stage = r_stage;
    w_done = r_done;
    w_lost = r_lost;
    // released stages form a thermometer code, so the next release shifts in a one
    w_shift = NUM_STAGES'({r_stage, 1'b1});
    w_abort = soft_rst_req && r_state != WAIT_LOCK;
`ifdef RESET_SEQUENCER_LOCK_MON_EN
    if (!w_abort && !r_lock_s && (r_state == RELEASE || r_state == RUN)) begin
      w_abort = 1'b1;
      w_lost = r_lost + {7'd0, r_lost != 8'hff};
    end
`endif
    if (w_abort) begin
      w_state = WAIT_LOCK;
      w_cnt = '0;
      w_stage = '0;
      w_done = 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          w_cnt = '0;
          w_stage = '0;
          w_done = 1'b0;
          w_state = r_lock_s ? STABLE : WAIT_LOCK;
        end
        STABLE: begin
          if (!r_lock_s) begin
            w_state = WAIT_LOCK;
            w_cnt = '0;
          end else if (r_cnt == CNT_W'(LOCK_STABLE - 1)) begin
            w_state = (NUM_STAGES == 1) ? RUN : RELEASE;
            w_stage = NUM_STAGES'(1);
            w_done = NUM_STAGES == 1;
            w_cnt = '0;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
            w_stage = w_shift;
            w_cnt = '0;
            w_state = (&w_shift) ? RUN : RELEASE;
            w_done = &w_shift;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        RUN: w_done = 1'b1;
        default: w_state = WAIT_LOCK;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_lock_s <= 1'b0;
      r_state <= WAIT_LOCK;
      r_cnt <= '0;
      r_stage <= '0;
      r_done <= 1'b0;
      r_lost <= '0;
    end else begin
      r_sync1 <= pll_locked;
      r_lock_s <= r_sync1;
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_stage <= w_stage;
      r_done <= w_done;
      r_lost <= w_lost;
    end
  end
  assign stage_rst_n = r_stage;
  assign seq_done = r_done;
  assign lock_lost_cnt = r_lost;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of staged release, lock glitch, soft reset, lock loss
// and async reset, plus a NUM_STAGES=1 / LOCK_STABLE=2 instance.
module tb_reset_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, soft_rst_req = 1'b0;
  logic [3:0] stage;
  logic done;
  logic [7:0] lost;
  logic [0:0] stage1;
  logic done1;
  logic [7:0] lost1;
  int total = 0, bad = 0, e = 0;

  always #5 clk = ~clk;

  reset_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .stage_rst_n(stage), .seq_done(done), .lock_lost_cnt(lost)
  );

  reset_sequencer #(.NUM_STAGES(1), .LOCK_STABLE(2), .STAGE_GAP(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .stage_rst_n(stage1), .seq_done(done1), .lock_lost_cnt(lost1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic go(input int k);
    while (e < k) tick();
  endtask

  task automatic wait_stage0(input string tag);
    int n = 0;
    while (!stage[0] && n < 200) begin
      tick();
      n++;
    end
    check(tag, {31'd0, stage[0]}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_stage", stage, 0);
    check("rst_done", done, 0);
    check("rst_lost", lost, 0);
    check("rst_stage1", {done1, stage1}, 0);
    rst_n = 1'b1;
    e = 0;
    go(9);
    pll_locked = 1'b1;
    go(13);
    check("n1_pre", {done1, stage1}, 2'b00);
    go(14);
    check("n1_rel", {done1, stage1}, 2'b11);
    go(75);  check("t1_e75", stage, 4'b0000);
    go(76);  check("t1_e76", stage, 4'b0001);
    go(91);  check("t1_e91", stage, 4'b0001);
    go(92);  check("t1_e92", stage, 4'b0011);
    go(107); check("t1_e107", stage, 4'b0011);
    go(108); check("t1_e108", stage, 4'b0111);
    go(123); check("t1_e123", {done, stage}, 5'b00111);
    go(124); check("t1_e124", {done, stage}, 5'b11111);
    go(130);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("t3_abort", {done, stage}, 5'b00000);
    go(195); check("t3_e195", stage, 4'b0000);
    go(196); check("t3_e196", stage, 4'b0001);
    go(243); check("t3_e243", {done, stage}, 5'b00111);
    go(244); check("t3_e244", {done, stage}, 5'b11111);
`ifdef RESET_SEQUENCER_LOCK_MON_EN
    go(250);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    go(331); check("t4_e331", stage, 4'b0001);
    go(332); check("t4_e332", stage, 4'b0011);
    go(335);
    pll_locked = 1'b0;
    go(337);
    check("t4_pre", stage, 4'b0011);
    check("t4_pre_lost", lost, 0);
    go(338);
    check("t4_abort", {done, stage}, 5'b00000);
    check("t4_lost1", lost, 1);
    for (int i = 0; i < 299; i++) begin
      pll_locked = 1'b1;
      wait_stage0("t4_relock");
      pll_locked = 1'b0;
      repeat (3) tick();
    end
    check("t4_sat", lost, 255);
    check("t4_sat_stage", stage, 4'b0000);
`else
    go(250);
    pll_locked = 1'b0;
    go(260);
    check("t5_hold", {done, stage}, 5'b11111);
    check("t5_lost", lost, 0);
`endif
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    pll_locked = 1'b1;
    wait_stage0("t6_rel0");
    repeat (20) tick();
    check("t6_mid", stage, 4'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async", {done, stage}, 5'b00000);
    check("t6_lost", lost, 0);
    pll_locked = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    e = 0;
    go(9);
    pll_locked = 1'b1;
    go(39);
    pll_locked = 1'b0;
    go(44);
    pll_locked = 1'b1;
    go(76);  check("t2_e76", stage, 4'b0000);
    go(110); check("t2_e110", stage, 4'b0000);
    go(111); check("t2_e111", stage, 4'b0001);
    check("t2_lost", lost, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
